sample_capture_writer: RTL and testbench
========================================

Name: sample_capture_writer

Overview:
- Avalon-MM write master that drives the 32-bit single-port on-chip sample memory, which is an Avalon slave with byteenable, chipselect, write, writedata and a 15-bit word address.
- Accepts a stream of 32-bit three-phase sample words and writes a block of block_len words starting at base_word.
- Addresses wrap inside the DEPTH_WORDS circular region.
- Sits between the ADC sample path and the Nios II data memory; signals block completion to software.

Parameters:
- DEPTH_WORDS, 25000: number of 32-bit words in the target memory; the address wrap point.
- FIFO_DEPTH, 4: entries in the internal ingress FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a capture when idle.
- base_word  in  15  first word index; sampled on accepted start.
- block_len  in  15  number of words to write; sampled on accepted start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; set when a sample is offered while the FIFO is full during CAPTURE; cleared by the next accepted start.
- words_written  out  15  count of words committed in the current or last block.
- snk_data  in  32  sample word.
- snk_valid  in  1  sample present.
- snk_ready  out  1  block accepts a sample this cycle.
- avm_address  out  17  byte address; equals word index shifted left by 2, low two bits always 0.
- avm_chipselect  out  1  asserted together with avm_write.
- avm_write  out  1  write request.
- avm_byteenable  out  4  always 4'b1111 while avm_write is high, else 0.
- avm_writedata  out  32  word being written.
- avm_waitrequest  in  1  interconnect stall.

Behaviour:
- Reset (clk edge with reset=1):
  - State returns to IDLE; FIFO is flushed.
  - busy, done, overflow, snk_ready, avm_write, avm_chipselect are 0.
  - avm_address, avm_writedata, avm_byteenable, words_written are 0.
  - Reset mid-block abandons the block; no done pulse; an in-flight write is dropped.
- States:
  - IDLE: start=1 latches base_word (reduced modulo DEPTH_WORDS) and block_len, clears words_written and overflow, sets busy. Next state is CAPTURE, or FINISH if block_len=0.
  - CAPTURE: snk_ready = FIFO not full AND (words accepted < block_len). A word is accepted when snk_valid & snk_ready. Samples beyond block_len are not accepted; this is not an overflow. snk_valid=1 while the FIFO is full sets overflow.
  - Write issue: in CAPTURE, when no write is pending and the FIFO is non-empty, pop the head.
    - Next cycle drive avm_write=avm_chipselect=1 with avm_address = cur_word<<2 and avm_writedata = head word.
    - Hold address, data and controls stable while avm_waitrequest=1.
    - The write commits on the first cycle with avm_write=1 and avm_waitrequest=0.
    - On commit: increment words_written; cur_word = cur_word+1, wrapping to 0 when it reaches DEPTH_WORDS.
    - Back-to-back writes are allowed: a new pop may occur in the commit cycle, giving 1 word per clock with no stall.
  - Leaving CAPTURE: when words_written reaches block_len, go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, return to IDLE.
- Simultaneous events:
  - Push and pop on the same cycle keep the FIFO count unchanged.
  - A full FIFO with a same-cycle pop still reports snk_ready=0; ready is registered from the count.
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
- Latency:
  - An accepted sample with an empty FIFO and an idle bus appears on avm_writedata 2 cycles after acceptance.
  - done occurs 1 cycle after the last commit.
- Widths: the word index is 15 bits; block_len above DEPTH_WORDS is allowed, and later words overwrite earlier ones after the wrap.

Test Plan:
- Basic block: base_word=0, block_len=8, samples 0x1000..0x1007 streamed continuously, waitrequest=0 -> 8 writes to byte addresses 0x0..0x1C in order; byteenable=F; done pulses once; words_written=8.
- Wrap: base_word=24998, block_len=4 -> writes at word indices 24998, 24999, 0, 1, i.e. byte addresses 0x18698, 0x1869C, 0x0, 0x4.
- Backpressure: waitrequest held high 3 cycles on every write -> address and data stable throughout each stall; FIFO fills; snk_ready drops; no data lost; overflow set only if the source keeps valid high while the FIFO is full.
- block_len=0: start -> done pulse 2 cycles later; no avm_write asserted; busy high for 1 cycle.
- Reset mid-block: assert reset after 3 of 10 commits -> next cycle all outputs 0, no done pulse; a fresh start with base_word=100 writes from byte address 0x190.
- Ignored start and sticky overflow: start pulsed while busy -> parameters unchanged. Force overflow, then issue a new start -> overflow clears.

Source files
------------

// File: rtl/sample_capture_writer_if.sv
// Sample stream ingress and Avalon-MM write bus of the capture writer.
// The writer block connects through the master modport; the stream source and memory side use slave.
interface sample_capture_writer_if;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;
  logic [16:0] avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    input  snk_data, snk_valid, avm_waitrequest,
    output snk_ready, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata
  );

  modport slave (
    output snk_data, snk_valid, avm_waitrequest,
    input  snk_ready, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata
  );
endinterface

// File: rtl/sample_capture_writer.sv
// Avalon-MM write master: buffers incoming sample words in a small FIFO and
// writes a block of them into a circular word region of the on-chip sample memory.
module sample_capture_writer #(
  parameter int unsigned DEPTH_WORDS = 25000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] base_word,
  input  logic [14:0] block_len,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [14:0] words_written,
  sample_capture_writer_if.master bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [14:0]   DEPTH_W  = 15'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;

  state_t        state_q, state_n;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_n;
  logic [14:0]   len_q, len_n;
  logic [14:0]   acc_q, acc_n;
  logic [14:0]   cur_word_q, cur_inc;
  logic          ready_q, ready_n;
  logic          wr_pend_q;
  logic [16:0]   addr_q;
  logic [31:0]   data_q;
  logic          start_ok, push, pop, commit, last_commit;
  logic          full, empty, ovf_hit;

  always_comb begin
    state_n     = state_q;
    start_ok    = 1'b0;
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    push        = bus.snk_valid & ready_q;
    commit      = wr_pend_q & ~bus.avm_waitrequest;
    // A new head may be popped in the same cycle the previous write commits.
    pop         = (state_q == CAPTURE) & ~empty & (~wr_pend_q | commit);
    last_commit = commit & ((words_written + 15'd1) == len_q);
    ovf_hit     = (state_q == CAPTURE) & bus.snk_valid & full & (acc_q < len_q);
    cur_inc     = (cur_word_q == (DEPTH_W - 15'd1)) ? '0 : (cur_word_q + 15'd1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = (block_len == '0) ? FINISH : CAPTURE;
        end
      end
      CAPTURE: begin
        if (last_commit) state_n = FINISH;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    len_n   = start_ok ? block_len : len_q;
    acc_n   = start_ok ? '0 : (acc_q + 15'(push));
    count_n = count_q;
    if (push & ~pop)      count_n = count_q + CW'(1);
    else if (pop & ~push) count_n = count_q - CW'(1);
    // Ready is registered, so it is derived from the next-cycle view of the FIFO and block.
    ready_n = (state_n == CAPTURE) & (count_n != FULL_CNT) & (acc_n < len_n);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.snk_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      len_q         <= '0;
      acc_q         <= '0;
      cur_word_q    <= '0;
      ready_q       <= 1'b0;
      wr_pend_q     <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      words_written <= '0;
    end else begin
      count_q <= count_n;
      len_q   <= len_n;
      acc_q   <= acc_n;
      ready_q <= ready_n;
      done    <= (state_q == FINISH);

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

      if (start_ok) begin
        busy          <= 1'b1;
        overflow      <= 1'b0;
        words_written <= '0;
        cur_word_q    <= base_word % DEPTH_W;
      end else begin
        if (state_q == FINISH) busy <= 1'b0;
        if (ovf_hit)           overflow <= 1'b1;
        if (commit) begin
          words_written <= words_written + 15'd1;
          cur_word_q    <= cur_inc;
        end
      end

      if (pop) begin
        wr_pend_q <= 1'b1;
        addr_q    <= {(commit ? cur_inc : cur_word_q), 2'b00};
        data_q    <= fifo_mem[rd_ptr_q];
      end else if (commit) begin
        wr_pend_q <= 1'b0;
      end
    end
  end

  assign bus.snk_ready      = ready_q;
  assign bus.avm_write      = wr_pend_q;
  assign bus.avm_chipselect = wr_pend_q;
  assign bus.avm_byteenable = wr_pend_q ? 4'hF : 4'h0;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;

endmodule

// File: tb/tb_sample_capture_writer.sv
// Directed bench for sample_capture_writer: expected writes are queued as samples
// are accepted and checked against the Avalon bus on every write cycle.
module tb_sample_capture_writer;
  localparam int unsigned DEPTH = 25000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [14:0] base_word = '0;
  logic [14:0] block_len = '0;
  logic        busy, done, overflow;
  logic [14:0] words_written;

  sample_capture_writer_if bus ();

  sample_capture_writer #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_word(base_word), .block_len(block_len),
    .busy(busy), .done(done), .overflow(overflow), .words_written(words_written), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [16:0] a; logic [31:0] d; } exp_t;
  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  int          wr_cnt = 0, done_cnt = 0;
  int unsigned exp_word = 0;
  bit          stall_mode = 1'b0, saw_wait = 1'b0;
  int          stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] d);
    exp_q.push_back('{a: 17'(exp_word << 2), d: d});
    exp_word = (exp_word + 1 == DEPTH) ? 0 : exp_word + 1;
  endtask

  // Memory side: optionally holds waitrequest for 3 cycles on every write.
  initial begin
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_mode && bus.avm_write && stall_cnt < 3) begin
        bus.avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        bus.avm_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // Every active write cycle must match the head of the queue; pop on commit.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.avm_write) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("wr_addr", 32'(bus.avm_address), 32'(exp_q[0].a));
          chk("wr_data", bus.avm_writedata, exp_q[0].d);
          chk("wr_be", 32'(bus.avm_byteenable), 32'hF);
          chk("wr_cs", 32'(bus.avm_chipselect), 1);
          if (!bus.avm_waitrequest) begin
            void'(exp_q.pop_front());
            wr_cnt++;
          end
        end
      end else begin
        chk("idle_be", 32'(bus.avm_byteenable), 0);
        chk("idle_cs", 32'(bus.avm_chipselect), 0);
      end
      if (done) done_cnt++;
    end
  end

  // Called at posedge+1; ends at posedge+1 after the start edge.
  task automatic do_start(input int unsigned b, input int unsigned l);
    @(posedge clk); #1;
    start = 1'b1; base_word = 15'(b); block_len = 15'(l);
    exp_word = b % DEPTH;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Polite sources raise valid only while ready is high.
  task automatic send(input logic [31:0] d, input bit polite);
    bit ok = 1'b0;
    bus.snk_data = d;
    for (int i = 0; i < 64; i++) begin
      if (bus.snk_ready) begin
        bus.snk_valid = 1'b1;
        push_exp(d);
        @(posedge clk); #1;
        bus.snk_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      saw_wait = 1'b1;
      bus.snk_valid = !polite;
      @(posedge clk); #1;
    end
    chk("send_accept", 32'(ok), 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_ww"}, 32'(words_written), 0);
    chk({tag, "_ready"}, 32'(bus.snk_ready), 0);
    chk({tag, "_write"}, 32'(bus.avm_write), 0);
    chk({tag, "_cs"}, 32'(bus.avm_chipselect), 0);
    chk({tag, "_be"}, 32'(bus.avm_byteenable), 0);
    chk({tag, "_addr"}, 32'(bus.avm_address), 0);
    chk({tag, "_data"}, bus.avm_writedata, 0);
  endtask

  initial begin
    int w0, d0;
    bit ok;
    bus.snk_data = '0;
    bus.snk_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1 reset = 1'b0;

    // Basic block of 8 words from word 0, continuous stream.
    w0 = wr_cnt; d0 = done_cnt;
    do_start(0, 8);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i), 1'b0);
    chk("t1_ready_after_len", 32'(bus.snk_ready), 0);
    bus.snk_data = 32'hDEAD_BEEF; bus.snk_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.snk_valid = 1'b0;
    wait_done(40);
    chk("t1_ww", 32'(words_written), 8);
    chk("t1_busy_at_done", 32'(busy), 0);
    chk("t1_ovf", 32'(overflow), 0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done), 0);
    chk("t1_writes", 32'(wr_cnt - w0), 8);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);

    // Single word: write appears 2 cycles after acceptance, done after the commit.
    do_start(5, 1);
    chk("lat_ready", 32'(bus.snk_ready), 1);
    bus.snk_data = 32'hABCD_0001; bus.snk_valid = 1'b1;
    push_exp(32'hABCD_0001);
    @(posedge clk); #1 bus.snk_valid = 1'b0;
    @(negedge clk);
    chk("lat_no_write_yet", 32'(bus.avm_write), 0);
    @(negedge clk);
    chk("lat_write", 32'(bus.avm_write), 1);
    chk("lat_addr", 32'(bus.avm_address), 32'h14);
    chk("lat_data", bus.avm_writedata, 32'hABCD_0001);
    @(negedge clk);
    chk("lat_ww", 32'(words_written), 1);
    chk("lat_done_early", 32'(done), 0);
    chk("lat_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_done", 32'(done), 1);
    chk("lat_busy_clr", 32'(busy), 0);
    @(negedge clk);
    chk("lat_done_clr", 32'(done), 0);

    // Wrap at the end of the region: 24998, 24999, 0, 1.
    w0 = wr_cnt;
    do_start(24998, 4);
    for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + 32'(i), 1'b0);
    wait_done(40);
    chk("wrap_ww", 32'(words_written), 4);
    chk("wrap_writes", 32'(wr_cnt - w0), 4);

    // Backpressure with a polite source: FIFO fills, no overflow, nothing lost.
    stall_mode = 1'b1; saw_wait = 1'b0;
    w0 = wr_cnt;
    do_start(50, 12);
    for (int i = 0; i < 12; i++) send(32'h3000 + 32'(i), 1'b1);
    wait_done(200);
    chk("bp_ready_dropped", 32'(saw_wait), 1);
    chk("bp_ovf", 32'(overflow), 0);
    chk("bp_ww", 32'(words_written), 12);
    chk("bp_writes", 32'(wr_cnt - w0), 12);

    // Pushy source forces overflow; a start while busy is ignored.
    w0 = wr_cnt;
    do_start(0, 10);
    for (int i = 0; i < 3; i++) send(32'h4000 + 32'(i), 1'b0);
    start = 1'b1; base_word = 15'd777; block_len = 15'd1;
    @(posedge clk); #1 start = 1'b0;
    chk("ign_busy", 32'(busy), 1);
    for (int i = 3; i < 10; i++) send(32'h4000 + 32'(i), 1'b0);
    wait_done(300);
    chk("ovf_set", 32'(overflow), 1);
    chk("ign_ww", 32'(words_written), 10);
    chk("ign_writes", 32'(wr_cnt - w0), 10);
    stall_mode = 1'b0;
    @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 1);

    // block_len=0: overflow clears, done 2 cycles after start, start in FINISH ignored.
    w0 = wr_cnt; d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; base_word = '0; block_len = '0;
    @(posedge clk); #1 start = 1'b1; base_word = 15'd7; block_len = 15'd3;
    @(negedge clk);
    chk("z_busy", 32'(busy), 1);
    chk("z_done_early", 32'(done), 0);
    chk("z_ovf_cleared", 32'(overflow), 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("z_done", 32'(done), 1);
    chk("z_busy_clr", 32'(busy), 0);
    @(negedge clk);
    chk("z_done_clr", 32'(done), 0);
    chk("z_finish_start_ignored", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("z_no_writes", 32'(wr_cnt - w0), 0);
    chk("z_done_cnt", 32'(done_cnt - d0), 1);

    // Reset after 3 of 10 commits, then a fresh block from word 100.
    do_start(0, 10);
    for (int i = 0; i < 5; i++) send(32'h5000 + 32'(i), 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (words_written == 15'd3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rm_reach3", 32'(ok), 1);
    reset = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    check_zero("rm");
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rm_no_done", 32'(done_cnt - d0), 0);
    chk("rm_idle", 32'(busy), 0);
    w0 = wr_cnt;
    do_start(100, 2);
    send(32'h6000, 1'b0);
    send(32'h6001, 1'b0);
    wait_done(40);
    chk("rm_ww", 32'(words_written), 2);
    chk("rm_writes", 32'(wr_cnt - w0), 2);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
